// File: rtl/rot_cmd_sequencer.sv
// Command sequencer for the 100-bit rotator: loads a word or issues
// single-step rotate enables, one per cycle, taking the shorter direction.
module rot_cmd_sequencer #(
    parameter int WIDTH    = 100,
    parameter int CNT_W    = 7,
    parameter int SHORTEST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rot_load,
    output logic [1:0]       rot_ena,
    output logic [WIDTH-1:0] rot_data,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [CNT_W:0] W_C    = (CNT_W+1)'(WIDTH);
    localparam logic [CNT_W:0] HALF_C = (CNT_W+1)'(WIDTH / 2);
    localparam logic [CNT_W:0] ONE_C  = (CNT_W+1)'(1);

    state_t         state, state_n;
    logic [CNT_W:0] step_cnt, step_n;
    logic [CNT_W:0] cnt_ext, eff, steps;
    logic [1:0]     dir_q, dir_n;
    logic           flip, accept, err_n;

    // One subtraction suffices: 2^CNT_W <= 2*WIDTH bounds the raw count.
    assign cnt_ext = {1'b0, cmd_count};
    assign eff     = (cnt_ext >= W_C) ? cnt_ext - W_C : cnt_ext;
    assign flip    = (SHORTEST != 0) && (eff > HALF_C);
    assign steps   = flip ? W_C - eff : eff;
    assign accept  = cmd_valid && (state == IDLE);

    always_comb begin
        state_n = state;
        step_n  = step_cnt;
        dir_n   = dir_q;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (cmd_op)
                        2'b00: state_n = LOAD;
                        2'b01, 2'b10: begin
                            dir_n   = flip ? {cmd_op[0], cmd_op[1]} : cmd_op;
                            step_n  = steps;
                            state_n = (steps == '0) ? DONE : RUN;
                        end
                        default: begin
                            state_n = DONE;
                            err_n   = 1'b1;
                        end
                    endcase
                end
            end
            LOAD: state_n = DONE;
            RUN: begin
                step_n = step_cnt - ONE_C;
                if (step_cnt <= ONE_C) begin
                    state_n = DONE;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state so they line up with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step_cnt  <= '0;
            dir_q     <= 2'b00;
            cmd_ready <= 1'b1;
            rot_load  <= 1'b0;
            rot_ena   <= 2'b00;
            rot_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_n;
            step_cnt  <= step_n;
            dir_q     <= dir_n;
            cmd_ready <= (state_n == IDLE);
            rot_load  <= (state_n == LOAD);
            rot_ena   <= (state_n == RUN) ? dir_n : 2'b00;
            busy      <= (state_n != IDLE);
            done      <= (state_n == DONE);
            cmd_err   <= err_n;
            if (accept && cmd_op == 2'b00) begin
                rot_data <= cmd_data;
            end
        end
    end

endmodule

// File: tb/tb_rot_cmd_sequencer.sv
// Randomized bench for rot_cmd_sequencer with a behavioural rotator and
// an arithmetic model of the expected final word and step counts.
module tb_rot_cmd_sequencer;

    localparam int W  = 100;
    localparam int CW = 7;
    localparam int SH = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [CW-1:0] cmd_count;
    logic [W-1:0]  cmd_data;
    logic          rot_load;
    logic [1:0]    rot_ena;
    logic [W-1:0]  rot_data;
    logic          busy;
    logic          done;
    logic          cmd_err;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] rq = '0;
    logic [W-1:0] exp_q;
    logic [W-1:0] last_load;
    bit           q_known;

    rot_cmd_sequencer #(
        .WIDTH(W),
        .CNT_W(CW),
        .SHORTEST(SH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_count(cmd_count),
        .cmd_data(cmd_data),
        .rot_load(rot_load),
        .rot_ena(rot_ena),
        .rot_data(rot_data),
        .busy(busy),
        .done(done),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // Downstream rotator: 01 rotates right, 10 rotates left.
    always_ff @(posedge clk) begin
        if (rot_load) rq <= rot_data;
        else if (rot_ena == 2'b01) rq <= {rq[0], rq[W-1:1]};
        else if (rot_ena == 2'b10) rq <= {rq[W-2:0], rq[W-1]};
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int k);
        if (k == 0) return v;
        return (v << k) | (v >> (W - k));
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int k);
        if (k == 0) return v;
        return (v >> k) | (v << (W - k));
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_load"}, rot_load, 0);
        chk({tag, "_ena"}, rot_ena, 0);
        chk({tag, "_data"}, rot_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, cmd_err, 0);
    endtask

    // Called at a negedge with the block idle; returns at a negedge, idle.
    task automatic run_cmd(input logic [1:0] op, input int count,
                           input logic [W-1:0] d, input bit hold);
        int k, nsteps, exp_done, exp_r, exp_l, exp_ld;
        int nr, nl, n11, nld, nbusy, ndata, dcyc;
        bit err_seen;
        exp_r = 0; exp_l = 0; exp_ld = 0;
        nr = 0; nl = 0; n11 = 0; nld = 0; nbusy = 0; ndata = 0; dcyc = 0;
        err_seen = 0;
        chk("ready_pre", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = CW'(count);
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = hold;
        cmd_op    = 2'($urandom);
        cmd_count = CW'($urandom);
        cmd_data  = rand_word();
        if (op == 2'b00) begin
            exp_done  = 2;
            exp_ld    = 1;
            exp_q     = d;
            last_load = d;
            q_known   = 1;
        end else if (op == 2'b11) begin
            exp_done = 1;
        end else begin
            k = count % W;
            nsteps = k;
            if (SH != 0 && k > W / 2) nsteps = W - k;
            exp_done = nsteps + 1;
            if ((op == 2'b01) == (nsteps == k)) exp_r = nsteps;
            else exp_l = nsteps;
            exp_q = (op == 2'b01) ? rotr(exp_q, k) : rotl(exp_q, k);
        end
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (rot_ena == 2'b01) nr++;
            if (rot_ena == 2'b10) nl++;
            if (rot_ena == 2'b11) n11++;
            if (rot_load) begin
                nld++;
                if (rot_data !== d) ndata++;
            end
            if (!busy || cmd_ready) nbusy++;
            if (done) begin
                dcyc = cyc;
                err_seen = cmd_err;
                break;
            end
        end
        if (dcyc == 0) chk("timeout", 0, 1);
        chk("done_cycle", dcyc, exp_done);
        chk("ena_right", nr, exp_r);
        chk("ena_left", nl, exp_l);
        chk("ena_11", n11, 0);
        chk("load_cycles", nld, exp_ld);
        chk("load_data", ndata, 0);
        chk("busy_ready", nbusy, 0);
        chk("cmd_err", err_seen, op == 2'b11);
        chk("rot_data_hold", rot_data, last_load);
        if (q_known) chk("q_final", rq, exp_q);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("ready_post", cmd_ready, 1);
        chk("idle_post", {busy, done, cmd_err, rot_load, rot_ena}, 0);
    endtask

    initial begin
        bit rst_done;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_count = '0;
        cmd_data  = '0;
        exp_q     = '0;
        last_load = '0;
        q_known   = 0;
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outs("post_rst");

        run_cmd(2'b00, 0, W'(1), 0);
        run_cmd(2'b10, 3, rand_word(), 0);
        run_cmd(2'b00, 0, W'(1), 0);
        run_cmd(2'b01, 70, '0, 0);
        run_cmd(2'b01, 100, '0, 0);
        run_cmd(2'b10, 0, '0, 0);
        run_cmd(2'b01, 127, '0, 1);
        run_cmd(2'b11, 5, '0, 0);
        run_cmd(2'b10, 51, '0, 1);
        run_cmd(2'b01, 50, '0, 0);

        // Reset during step 10 of a 40-step rotate.
        run_cmd(2'b00, 0, rand_word(), 0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_count = CW'(40);
        @(posedge clk);
        repeat (10) @(negedge clk);
        chk("mid_ena", rot_ena, 2'b10);
        rst_n = 1'b0;
        #1;
        check_reset_outs("mid_rst");
        rst_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) rst_done = 1;
        end
        chk("no_done_rst", rst_done, 0);
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        last_load = '0;
        q_known   = 0;
        @(negedge clk);
        check_reset_outs("rel_rst");

        run_cmd(2'b00, 0, rand_word(), 0);
        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            int r;
            r  = int'($urandom_range(0, 9));
            op = (r < 2) ? 2'b00 : (r < 5) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            run_cmd(op, int'($urandom_range(0, 127)), rand_word(),
                    1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rot_cmd_sequencer.md
# rot_cmd_sequencer

Command sequencer that sits directly upstream of the 100-bit left/right rotator and drives its `load`, `ena[1:0]` and `data[99:0]` inputs. It accepts one command at a time over a valid/ready handshake: load a word, or rotate left/right by a multi-step count. It reduces the count modulo the width and, optionally, takes the shorter direction. It then issues one single-step enable per cycle and pulses `done` in the first cycle the rotator output holds the final result.

## Interface
Parameters:
- `WIDTH`, 100, rotator width; must match the downstream rotator.
- `CNT_W`, 7, width of `cmd_count`; constraint 2^CNT_W <= 2*WIDTH.
- `SHORTEST`, 1, when 1, rotations longer than WIDTH/2 are executed in the opposite direction.

Ports:
- `clk`  in  1  rising-edge clock; the single clock for the block.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  2  00 load, 01 rotate right, 10 rotate left, 11 reserved.
- `cmd_count`  in  CNT_W  rotate step count; ignored for load and reserved.
- `cmd_data`  in  WIDTH  load word; ignored for rotates.
- `rot_load`  out  1  to rotator `load`.
- `rot_ena`  out  2  to rotator `ena`; 01 right, 10 left.
- `rot_data`  out  WIDTH  to rotator `data`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `cmd_err`  out  1  one-cycle pulse with `done` for a reserved op.

## Operation
- States: IDLE, LOAD, RUN, DONE. `cmd_ready` = (state == IDLE). All outputs are registered.
- Accept occurs on a rising edge with `cmd_valid && cmd_ready`. Op, direction, effective count and data are captured on that edge.
- Effective count:
  - eff = `cmd_count` if `cmd_count` < WIDTH, else `cmd_count` − WIDTH.
  - If SHORTEST=1 and eff > WIDTH/2 (integer), the direction flips and steps = WIDTH − eff. Otherwise steps = eff.
  - Example: 127 → 27; 70 right → 30 left; 50 stays 50.
- IDLE → LOAD on an accepted op 00.
- IDLE → RUN on an accepted rotate with steps ≥ 1.
- IDLE → DONE on an accepted rotate with steps = 0, or on op 11.
- LOAD: `rot_load`=1 for exactly one cycle, `rot_data`=captured word, then → DONE.
- RUN:
  - `rot_ena` = direction code for exactly `steps` consecutive cycles. The step counter decrements each cycle.
  - On the last step the state moves → DONE.
  - `rot_load`=0 throughout.
- DONE: `done`=1 and `cmd_err`=1 if the op was 11. `rot_ena`=00 and `rot_load`=0. Next state is IDLE.
- `rot_data` holds the last captured load word until the next load is accepted. It is not updated by rotate commands.
- Outside LOAD, `rot_load`=0. Outside RUN, `rot_ena`=00. The block never drives `ena`=11.

## Timing
- Reset values:
  - `cmd_ready`=1, `rot_load`=0, `rot_ena`=00, `rot_data`=0.
  - `busy`=0, `done`=0, `cmd_err`=0.
  - State is IDLE; step counter is 0.
- Accept at edge t0 → first active output cycle begins at t0.
- Load command: `rot_load` high in cycle 1, `done` in cycle 2. Three cycles from accept to the next possible accept.
- Rotate of `steps`=N: `rot_ena` high in cycles 1..N, `done` in cycle N+1. `done` coincides with the rotator `q` reflecting the final value.
- Zero-step rotate and reserved op: `done` in cycle 1, no rotator activity.
- `cmd_valid` held while `cmd_ready`=0 is ignored. Command inputs need not be stable after the accept edge.
- Reset mid-command: all outputs return to their reset values immediately, the command is dropped, and no `done` is issued. The rotator contents are not restored.

## Test plan
- Reset, then load 0x1 (op 00): `rot_load` high 1 cycle with `rot_data`=1. `done` the next cycle. Rotator q=1.
- After loading 0x1, rotate left count 3: `rot_ena`=10 for 3 cycles, then `done`. q=0x8.
- Load 0x1, rotate right count 70 with SHORTEST=1: `rot_ena`=10 for 30 cycles. Final q = 1<<30. With SHORTEST=0: `rot_ena`=01 for 70 cycles, same final q.
- Rotate count 100 and count 0: no `rot_ena` activity; `done` 1 cycle after accept. Count 127 right: 27 steps right.
- Op 11: `done` and `cmd_err` high together 1 cycle after accept; `rot_load`=0 and `rot_ena`=00 throughout.
- Assert `rst_n` low during step 10 of a 40-step rotate: outputs immediately at reset values, no `done`. `cmd_ready`=1 after release. `cmd_valid` held during RUN is not accepted early.
